// File: rtl/ci_frame_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : ci_frame_loader_if
// Description : Nios II multicycle custom-instruction bus between the CPU
//               (master) and the frame loader (slave).
//   start  : CI start, one-cycle pulse from the CPU
//   dataa  : 32-pixel word, bit k = pixel at base+k
//   datab  : [6:0] word index, [31] clear command (when FRAME_CLEAR_EN)
//   result : popcount of pixels written by the last instruction
//   done   : CI done, one-cycle pulse
//   busy   : high while pixels are being written
// Revision    : 1.0 - initial release
// ============================================================================
interface ci_frame_loader_if;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;
  logic        busy;

  modport master (
    output start, dataa, datab,
    input  result, done, busy
  );

  modport slave (
    input  start, dataa, datab,
    output result, done, busy
  );
endinterface
`default_nettype wire

// File: rtl/ci_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : ci_frame_loader
// Description : Multicycle custom-instruction slave that loads a 64x64 1-bit
//               frame buffer. Each instruction writes one 32-pixel word
//               bit-serially (LSB first) into the RAM write port, one pixel
//               per clock. The scan-out side of the RAM is not touched here.
// Ports       :
//   clk      in   system clock, also clocks the RAM write port
//   reset_n  in   asynchronous active-low reset
//   ci       if   custom-instruction bus (slave modport)
//   wr_addr  out  RAM write address
//   wr_data  out  RAM write data
//   wren     out  RAM write enable
// Options     : define FRAME_CLEAR_EN to add the whole-frame CLEAR command
//               (datab[31]=1 fills all 4096 pixels with dataa[0]).
// Revision    : 1.0 - initial release
// ============================================================================
module ci_frame_loader #(
  parameter int IMG_PIX = 4096,
  parameter int ADDR_W  = 12,
  parameter int WORD_W  = 32
) (
  input  wire                clk,
  input  wire                reset_n,
  ci_frame_loader_if.slave   ci,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic               wr_data,
  output logic               wren
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
`ifdef FRAME_CLEAR_EN
    ST_CLEAR = 2'd3,
`endif
    ST_DONE  = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(WORD_W);
  localparam int POP_W = ADDR_W + 1;

  state_t             r_state;
  logic [WORD_W-1:0]  r_shreg;
  logic [CNT_W-1:0]   r_cnt;
  logic [POP_W-1:0]   r_pop;
`ifdef FRAME_CLEAR_EN
  logic               r_fill;
`endif

  // Word base address: word index times 32. datab[30:7] never reach it.
  wire [ADDR_W-1:0] w_base = ADDR_W'({ci.datab[6:0], 5'b0_0000});

`ifdef FRAME_CLEAR_EN
  wire w_unused_datab = ^ci.datab[30:7];
`else
  wire w_unused_datab = ^ci.datab[31:7];
`endif

  // All outputs are registered. Pixel 0 is presented on the same edge that
  // accepts start, so the pixels occupy exactly cycles 1..32 and done lands
  // on cycle 33. wr_addr/wr_data are held when wren drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_pop     <= '0;
`ifdef FRAME_CLEAR_EN
      r_fill    <= 1'b0;
`endif
      wr_addr   <= '0;
      wr_data   <= 1'b0;
      wren      <= 1'b0;
      ci.result <= '0;
      ci.done   <= 1'b0;
      ci.busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          ci.done <= 1'b0;
          if (ci.start) begin
            wren    <= 1'b1;
            ci.busy <= 1'b1;
`ifdef FRAME_CLEAR_EN
            if (ci.datab[31]) begin
              r_fill  <= ci.dataa[0];
              wr_addr <= '0;
              wr_data <= ci.dataa[0];
              r_state <= ST_CLEAR;
            end else
`endif
            begin
              // Pixel 0 goes out now; the register keeps the remaining 31.
              wr_addr <= w_base;
              wr_data <= ci.dataa[0];
              r_shreg <= ci.dataa >> 1;
              r_cnt   <= '0;
              r_pop   <= POP_W'(ci.dataa[0]);
              r_state <= ST_WRITE;
            end
          end
        end

        ST_WRITE: begin
          if (r_cnt == CNT_W'(WORD_W - 1)) begin
            wren      <= 1'b0;
            ci.busy   <= 1'b0;
            ci.done   <= 1'b1;
            ci.result <= 32'(r_pop);
            r_state   <= ST_DONE;
          end else begin
            wr_addr <= wr_addr + 1'b1;
            wr_data <= r_shreg[0];
            r_shreg <= r_shreg >> 1;
            r_pop   <= r_pop + POP_W'(r_shreg[0]);
            r_cnt   <= r_cnt + 1'b1;
          end
        end

`ifdef FRAME_CLEAR_EN
        ST_CLEAR: begin
          // wr_addr doubles as the fill counter; it terminates at the top cell.
          if (wr_addr == ADDR_W'(IMG_PIX - 1)) begin
            wren      <= 1'b0;
            ci.busy   <= 1'b0;
            ci.done   <= 1'b1;
            ci.result <= r_fill ? 32'(IMG_PIX) : 32'd0;
            r_state   <= ST_DONE;
          end else begin
            wr_addr <= wr_addr + 1'b1;
          end
        end
`endif

        ST_DONE: begin
          ci.done <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          wren    <= 1'b0;
          ci.busy <= 1'b0;
          ci.done <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ci_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ci_frame_loader
// Description : Directed self-checking bench for ci_frame_loader. Drives
//               custom instructions through the CI interface and checks the
//               RAM write stream, done/busy timing and the popcount result
//               against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ci_frame_loader;

  logic        clk;
  logic        reset_n;
  logic [11:0] wr_addr;
  logic        wr_data;
  logic        wren;

  ci_frame_loader_if ci ();

  ci_frame_loader #(
    .IMG_PIX (4096),
    .ADDR_W  (12),
    .WORD_W  (32)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ci      (ci),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wren    (wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int wcnt;
  logic [11:0] last_addr;

  // RAM write-port observer: counts the writes actually committed on an edge.
  always @(posedge clk) begin
    if (wren) begin
      wcnt      = wcnt + 1;
      last_addr = wr_addr;
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One word instruction. glitch_cyc: cycle on which a stray start is driven
  // (0 = none). rst_cyc: cycle on which reset_n is pulled low (0 = none).
  task automatic run_word(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [11:0] base, input logic [31:0] exp_res,
                          input int glitch_cyc, input int rst_cyc);
    logic [31:0] av;
    av = a;
    @(negedge clk);
    wcnt     = 0;
    ci.start = 1'b1;
    ci.dataa = a;
    ci.datab = b;
    @(posedge clk); #1;
    ci.start = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      if (c == rst_cyc) begin
        reset_n = 1'b0;
        #1;
        check_vec({tag, " rst wren"}, 32'(wren), 32'd0);
        check_vec({tag, " rst busy"}, 32'(ci.busy), 32'd0);
        check_vec({tag, " rst done"}, 32'(ci.done), 32'd0);
        check_vec({tag, " rst addr"}, 32'(wr_addr), 32'd0);
        check_vec({tag, " rst wcnt"}, 32'(wcnt), 32'(c - 1));
        check_vec({tag, " rst last"}, 32'(last_addr), 32'(base) + 32'(c - 2));
        @(posedge clk);
        @(negedge clk);
        check_vec({tag, " rst hold"}, 32'(wcnt), 32'(c - 1));
        reset_n = 1'b1;
        return;
      end
      ci.start = (c == glitch_cyc);
      check_vec({tag, " wren"}, 32'(wren), 32'd1);
      check_vec({tag, " busy"}, 32'(ci.busy), 32'd1);
      check_vec({tag, " done"}, 32'(ci.done), 32'd0);
      check_vec({tag, " addr"}, 32'(wr_addr), 32'(base) + 32'(c - 1));
      check_vec({tag, " data"}, 32'(wr_data), 32'(av[c-1]));
      @(posedge clk); #1;
    end
    ci.start = 1'b0;
    check_vec({tag, " done33"}, 32'(ci.done), 32'd1);
    check_vec({tag, " wren33"}, 32'(wren), 32'd0);
    check_vec({tag, " busy33"}, 32'(ci.busy), 32'd0);
    check_vec({tag, " result"}, ci.result, exp_res);
    check_vec({tag, " addr held"}, 32'(wr_addr), 32'(base) + 32'd31);
    check_vec({tag, " wcnt"}, 32'(wcnt), 32'd32);
    @(posedge clk); #1;
    check_vec({tag, " done34"}, 32'(ci.done), 32'd0);
    check_vec({tag, " wren34"}, 32'(wren), 32'd0);
    check_vec({tag, " result held"}, ci.result, exp_res);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    wcnt     = 0;
    last_addr = '0;
    reset_n  = 1'b0;
    ci.start = 1'b0;
    ci.dataa = '0;
    ci.datab = '0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("reset result", ci.result, 32'd0);
    check_vec("reset done",   32'(ci.done), 32'd0);
    check_vec("reset busy",   32'(ci.busy), 32'd0);
    check_vec("reset wren",   32'(wren), 32'd0);
    check_vec("reset addr",   32'(wr_addr), 32'd0);
    check_vec("reset data",   32'(wr_data), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    run_word("t1 alt",   32'hAAAA_AAAA, 32'h0000_0000, 12'd0,    32'd16, 0,  0);
    run_word("t2 top",   32'hFFFF_FFFF, 32'h0000_007F, 12'd4064, 32'd32, 0,  0);
    run_word("t3 upper", 32'h0000_F00F, 32'h00FF_FF85, 12'd160,  32'd8,  10, 0);
    // No restart after the stray start: the bus must stay idle.
    repeat (3) begin
      @(posedge clk); #1;
      check_vec("t3 no restart", 32'(wren), 32'd0);
    end
    run_word("t4 reset", 32'h1234_5678, 32'h0000_0000, 12'd0,    32'd13, 0, 15);
    check_vec("t4 post result", ci.result, 32'd0);
    run_word("t4 after", 32'h8000_0001, 32'h0000_0003, 12'd96,   32'd2,  0,  0);

`ifdef FRAME_CLEAR_EN
    @(negedge clk);
    wcnt     = 0;
    ci.start = 1'b1;
    ci.dataa = 32'h0000_0001;
    ci.datab = 32'h8000_0000;
    @(posedge clk); #1;
    ci.start = 1'b0;
    for (int c = 1; c <= 4096; c++) begin
      check_vec("t5 wren", 32'(wren), 32'd1);
      check_vec("t5 addr", 32'(wr_addr), 32'(c - 1));
      check_vec("t5 data", 32'(wr_data), 32'd1);
      @(posedge clk); #1;
    end
    check_vec("t5 done",   32'(ci.done), 32'd1);
    check_vec("t5 busy",   32'(ci.busy), 32'd0);
    check_vec("t5 result", ci.result, 32'd4096);
    check_vec("t5 wcnt",   32'(wcnt), 32'd4096);
    @(posedge clk); #1;
    check_vec("t5 done off", 32'(ci.done), 32'd0);
`else
    run_word("t6 noclr", 32'h0000_0001, 32'h8000_0002, 12'd64, 32'd1, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
